// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: circular retire trace with pc trigger, cycle limit and wrap/stop modes.
// Define TRACE_UNKNOWN_EN to build the unsupported-opcode counter.
module inst_trace_buffer #(
  parameter int DEPTH = 64,
  parameter int PCWIDTH = 32,
  parameter int INSTWIDTH = 32,
  parameter int CYCLELIMIT = 1024
) (
  input  logic                     clock_i,
  input  logic                     nreset_i,
  input  logic                     valid_i,
  input  logic [PCWIDTH-1:0]       pc_i,
  input  logic [INSTWIDTH-1:0]     inst_i,
  input  logic                     arm_i,
  input  logic                     trig_en_i,
  input  logic [PCWIDTH-1:0]       trig_pc_i,
  input  logic                     mode_i,
  input  logic [$clog2(DEPTH)-1:0] rd_index_i,
  input  logic                     rd_en_i,
  output logic [PCWIDTH-1:0]       rd_pc_o,
  output logic [INSTWIDTH-1:0]     rd_inst_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     wrapped_o,
  output logic                     capturing_o,
  output logic                     done_o,
  output logic [15:0]              unknown_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, FROZEN} state_e;
  state_e state_q;
  logic [PCWIDTH-1:0] pc_mem [DEPTH];
  logic [INSTWIDTH-1:0] inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0] count_q;
  logic wrapped_q, done_q, mode_q;
  logic [31:0] cyc_q, cyc_d;
  logic [PCWIDTH-1:0] rd_pc_q;
  logic [INSTWIDTH-1:0] rd_inst_q;
  logic rd_valid_q;
  logic trig_hit, in_cap, wr_en, full, cyc_end, rd_hit;
  logic [AW-1:0] phys;
  always_comb begin
    trig_hit = state_q == WAIT_TRIG && valid_i && pc_i == trig_pc_i;
    in_cap = !arm_i && (state_q == CAPTURE || trig_hit);
    wr_en = in_cap && valid_i;
    full = count_q == FULL;
    cyc_d = cyc_q + 32'd1;
    cyc_end = CYCLELIMIT != 0 && cyc_d == 32'(CYCLELIMIT);
    phys = wrapped_q ? wr_ptr_q + rd_index_i : rd_index_i;
    rd_hit = rd_en_i && {1'b0, rd_index_i} < count_q;
  end
  always_ff @(posedge clock_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      count_q <= '0;
      wrapped_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
      cyc_q <= '0;
    end else if (arm_i) begin
      state_q <= trig_en_i ? WAIT_TRIG : CAPTURE;
      wr_ptr_q <= '0;
      count_q <= '0;
      wrapped_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= mode_i;
      cyc_q <= '0;
    end else begin
      if (in_cap) cyc_q <= cyc_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (!full) count_q <= count_q + (AW+1)'(1);
        if (full && !mode_q) wrapped_q <= 1'b1;
      end
      // Freeze on the limit cycle, or on the write that fills the buffer in stop mode.
      if (in_cap && (cyc_end || (wr_en && mode_q && count_q == LAST))) begin
        state_q <= FROZEN;
        done_q <= 1'b1;
      end else if (trig_hit) begin
        state_q <= CAPTURE;
      end
    end
  end
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q] <= pc_i;
      inst_mem[wr_ptr_q] <= inst_i;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!nreset_i) begin
      rd_valid_q <= 1'b0;
      rd_pc_q <= '0;
      rd_inst_q <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_pc_q <= rd_hit ? pc_mem[phys] : '0;
      rd_inst_q <= rd_hit ? inst_mem[phys] : '0;
    end
  end
`ifdef TRACE_UNKNOWN_EN
  logic [15:0] unk_q;
  logic known;
  always_comb known = inst_i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  always_ff @(posedge clock_i) begin
    if (!nreset_i || arm_i) unk_q <= '0;
    else if (wr_en && !known && unk_q != 16'hFFFF) unk_q <= unk_q + 16'd1;
  end
  assign unknown_cnt_o = unk_q;
`else
  assign unknown_cnt_o = '0;
`endif
  assign rd_pc_o = rd_pc_q;
  assign rd_inst_o = rd_inst_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o = count_q;
  assign wrapped_o = wrapped_q;
  assign capturing_o = state_q == CAPTURE;
  assign done_o = done_q;
endmodule

// File: tb/tb_inst_trace_buffer.sv
// tb_inst_trace_buffer: read requests push expected responses; a monitor checks them one cycle later.
module tb_inst_trace_buffer;
  logic clk = 0, nreset = 0, valid = 0, arm = 0, trig_en = 0, mode = 0, rd_en = 0;
  logic [31:0] pc = 0, inst = 0, trig_pc = 0;
  logic [5:0] rd_index = 0;
  logic [31:0] m_pc, m_inst, l_pc, l_inst;
  logic m_v, m_wr, m_cap, m_dn, l_v, l_wr, l_cap, l_dn;
  logic [6:0] m_cnt, l_cnt;
  logic [15:0] m_unk, l_unk;
  logic rd_seen = 0;
  int n_vec = 0, n_miss = 0;
  typedef struct packed {
    logic sel; logic v; logic [31:0] pc; logic [31:0] inst;
    logic [6:0] cnt; logic wr; logic dn; logic cap; logic [15:0] unk;
  } exp_t;
  exp_t q[$];
  string tq[$];
`ifdef TRACE_UNKNOWN_EN
  localparam logic [15:0] UE = 16'd2;
`else
  localparam logic [15:0] UE = 16'd0;
`endif
  always #5 clk = ~clk;
  inst_trace_buffer #(.DEPTH(64), .PCWIDTH(32), .INSTWIDTH(32), .CYCLELIMIT(0)) u_main (
    .clock_i(clk), .nreset_i(nreset), .valid_i(valid), .pc_i(pc), .inst_i(inst), .arm_i(arm),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .mode_i(mode), .rd_index_i(rd_index), .rd_en_i(rd_en),
    .rd_pc_o(m_pc), .rd_inst_o(m_inst), .rd_valid_o(m_v), .count_o(m_cnt), .wrapped_o(m_wr),
    .capturing_o(m_cap), .done_o(m_dn), .unknown_cnt_o(m_unk));
  inst_trace_buffer #(.DEPTH(64), .PCWIDTH(32), .INSTWIDTH(32), .CYCLELIMIT(16)) u_lim (
    .clock_i(clk), .nreset_i(nreset), .valid_i(valid), .pc_i(pc), .inst_i(inst), .arm_i(arm),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .mode_i(mode), .rd_index_i(rd_index), .rd_en_i(rd_en),
    .rd_pc_o(l_pc), .rd_inst_o(l_inst), .rd_valid_o(l_v), .count_o(l_cnt), .wrapped_o(l_wr),
    .capturing_o(l_cap), .done_o(l_dn), .unknown_cnt_o(l_unk));
  function automatic logic [31:0] ins(input logic [31:0] p);
    return {p[24:0], 7'h33};
  endfunction
  always @(posedge clk) rd_seen <= rd_en;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (q.size() == 0) begin
        $display("FAIL unexpected_response no expectation queued");
        n_miss++;
      end else begin
        exp_t e, a;
        string t;
        e = q.pop_front();
        t = tq.pop_front();
        a = e.sel ? {1'b1, l_v, l_pc, l_inst, l_cnt, l_wr, l_dn, l_cap, l_unk}
                  : {1'b0, m_v, m_pc, m_inst, m_cnt, m_wr, m_dn, m_cap, m_unk};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL %s got v=%b pc=%h inst=%h cnt=%0d wr=%b dn=%b cap=%b unk=%0d want v=%b pc=%h inst=%h cnt=%0d wr=%b dn=%b cap=%b unk=%0d",
                   t, a.v, a.pc, a.inst, a.cnt, a.wr, a.dn, a.cap, a.unk, e.v, e.pc, e.inst, e.cnt, e.wr, e.dn, e.cap, e.unk);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_arm(input logic te, input logic [31:0] tp, input logic md);
    arm = 1; trig_en = te; trig_pc = tp; mode = md;
    tick();
    arm = 0;
  endtask
  task automatic retire(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      valid = 1; pc = 32'(base + i * step); inst = ins(32'(base + i * step));
      tick();
    end
    valid = 0;
  endtask
  task automatic rd(input logic s, input int idx, input logic v, input logic [31:0] p, input logic [31:0] i_,
                    input logic [6:0] c, input logic w, input logic d, input logic cp, input logic [15:0] u, input string t);
    rd_en = 1; rd_index = 6'(idx);
    q.push_back({s, v, p, i_, c, w, d, cp, u});
    tq.push_back(t);
    tick();
    rd_en = 0;
  endtask
  initial begin
    repeat (3) tick();
    nreset = 1;
    tick();
    rd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state");
    do_arm(0, 0, 0);
    retire(8, 0, 4);
    rd(0, 3, 1, 12, ins(12), 8, 0, 0, 1, 0, "wrap8_idx3");
    rd(0, 8, 0, 0, 0, 8, 0, 0, 1, 0, "wrap8_idx8_invalid");
    do_arm(0, 0, 0);
    retire(70, 0, 4);
    rd(0, 0, 1, 24, ins(24), 64, 1, 0, 1, 0, "wrap70_oldest");
    rd(0, 63, 1, 276, ins(276), 64, 1, 0, 1, 0, "wrap70_newest");
    rd(0, 32, 1, 152, ins(152), 64, 1, 0, 1, 0, "wrap70_mid");
    do_arm(0, 0, 1);
    retire(70, 0, 4);
    rd(0, 63, 1, 252, ins(252), 64, 0, 1, 0, 0, "stop70_idx63");
    rd(0, 0, 1, 0, ins(0), 64, 0, 1, 0, 0, "stop70_idx0");
    do_arm(1, 40, 0);
    rd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "trig_waiting");
    retire(21, 0, 4);
    rd(0, 0, 1, 40, ins(40), 11, 0, 0, 1, 0, "trig_first");
    rd(0, 10, 1, 80, ins(80), 11, 0, 0, 1, 0, "trig_last");
    rd(0, 11, 0, 0, 0, 11, 0, 0, 1, 0, "trig_past_end");
    do_arm(0, 0, 0);
    retire(20, 0, 4);
    rd(1, 15, 1, 60, ins(60), 16, 0, 1, 0, 0, "limit_idx15");
    rd(1, 16, 0, 0, 0, 16, 0, 1, 0, 0, "limit_idx16_invalid");
    rd(0, 19, 1, 76, ins(76), 20, 0, 0, 1, 0, "nolimit_idx19");
    arm = 1; valid = 1; pc = 100; inst = ins(100);
    tick();
    arm = 0; valid = 0;
    rd(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "arm_beats_valid");
    retire(1, 200, 4);
    rd(0, 0, 1, 200, ins(200), 1, 0, 0, 1, 0, "after_arm_valid");
    do_arm(0, 0, 0);
    valid = 1; pc = 0; inst = 32'h0000006F; tick();
    pc = 4; tick();
    pc = 8; inst = ins(8); tick();
    valid = 0;
    rd(0, 0, 1, 0, 32'h0000006F, 3, 0, 0, 1, UE, "unknown_jal");
    rd(0, 2, 1, 8, ins(8), 3, 0, 0, 1, UE, "unknown_add");
    do_arm(0, 0, 0);
    retire(3, 0, 4);
    nreset = 0; tick(); nreset = 1;
    rd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_mid_capture");
    repeat (4) tick();
    if (q.size() != 0) begin
      $display("FAIL missing_responses got %0d outstanding want 0", q.size());
      n_miss += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
